// File: rtl/junit_xml_reader_pkg.sv
// Shared definitions for the JUnit-XML stream reader.
// Contents:
//   state_t      - parser FSM states
//   err_code_t   - sticky error codes reported on err_code
//   CH_*         - ASCII byte constants the parser reacts to
//   TAG_*        - recognised element names (right-justified byte strings) and their lengths
//   M_*          - bit positions in the name-match vector
//   is_*         - byte classification helpers
package junit_xml_reader_pkg;

  typedef enum logic [3:0] {
    ST_TEXT,
    ST_LT,
    ST_NAME,
    ST_ATTR,
    ST_QUOTE,
    ST_SLASH,
    ST_CLOSE,
    ST_DECL,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_UNDERFLOW = 3'd1,
    ERR_OVERFLOW  = 3'd2,
    ERR_BAD_TAG   = 3'd3,
    ERR_TRUNC     = 3'd4
  } err_code_t;

  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_GT     = 8'h3E;
  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_QMARK  = 8'h3F;
  localparam logic [7:0] CH_BANG   = 8'h21;
  localparam logic [7:0] CH_DQUOTE = 8'h22;
  localparam logic [7:0] CH_SQUOTE = 8'h27;

  // Longest recognised name; the capture buffer must hold at least this many bytes.
  localparam int TAG_BYTES_MAX = 9;

  // String literals are right-justified: the first character sits in the
  // highest occupied byte, i.e. at byte index LEN-1 from the LSB.
  localparam logic [8*TAG_BYTES_MAX-1:0] TAG_SUITE   = "testsuite";
  localparam logic [8*TAG_BYTES_MAX-1:0] TAG_CASE    = "testcase";
  localparam logic [8*TAG_BYTES_MAX-1:0] TAG_FAILURE = "failure";
  localparam logic [8*TAG_BYTES_MAX-1:0] TAG_ERROR   = "error";
  localparam logic [8*TAG_BYTES_MAX-1:0] TAG_SKIPPED = "skipped";
  localparam int TAG_SUITE_LEN   = 9;
  localparam int TAG_CASE_LEN    = 8;
  localparam int TAG_FAILURE_LEN = 7;
  localparam int TAG_ERROR_LEN   = 5;
  localparam int TAG_SKIPPED_LEN = 7;

  localparam int M_SUITE   = 4;
  localparam int M_CASE    = 3;
  localparam int M_FAILURE = 2;
  localparam int M_ERROR   = 1;
  localparam int M_SKIPPED = 0;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_name_start(input logic [7:0] c);
    return is_alpha(c) || (c == 8'h5F);
  endfunction

  function automatic logic is_name_char(input logic [7:0] c);
    return is_name_start(c) || is_digit(c) ||
           (c == 8'h2D) || (c == 8'h2E) || (c == 8'h3A);
  endfunction

  function automatic logic is_space(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

endpackage

// File: rtl/junit_xml_name_match.sv
// Combinational tag-name recogniser.
// Ports:
//   name_buf [8*NAME_MAX] in  - captured name, byte i at bits [8*i +: 8]
//   name_len [LEN_W]      in  - captured length (may exceed NAME_MAX, saturating)
//   match    [5]          out - one-hot {suite, case, failure, error, skipped}
// A match needs exact length and exact, case-sensitive bytes.
module junit_xml_name_match #(
  parameter int NAME_MAX = 16,
  parameter int LEN_W    = 6
) (
  input  logic [8*NAME_MAX-1:0] name_buf,
  input  logic [LEN_W-1:0]      name_len,
  output logic [4:0]            match
);
  import junit_xml_reader_pkg::*;

  function automatic logic name_is(input logic [8*NAME_MAX-1:0]      b,
                                   input logic [LEN_W-1:0]           l,
                                   input logic [8*TAG_BYTES_MAX-1:0] s,
                                   input int                         sl);
    logic ok;
    ok = (int'(l) == sl);
    for (int i = 0; i < NAME_MAX; i++) begin
      if (i < sl) begin
        if (b[8*i +: 8] != s[8*(sl-1-i) +: 8]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  always_comb begin
    match            = '0;
    match[M_SUITE]   = name_is(name_buf, name_len, TAG_SUITE,   TAG_SUITE_LEN);
    match[M_CASE]    = name_is(name_buf, name_len, TAG_CASE,    TAG_CASE_LEN);
    match[M_FAILURE] = name_is(name_buf, name_len, TAG_FAILURE, TAG_FAILURE_LEN);
    match[M_ERROR]   = name_is(name_buf, name_len, TAG_ERROR,   TAG_ERROR_LEN);
    match[M_SKIPPED] = name_is(name_buf, name_len, TAG_SKIPPED, TAG_SKIPPED_LEN);
  end

endmodule

// File: rtl/junit_xml_reader.sv
// Streaming byte-serial JUnit-XML reader: counts testsuite/testcase/failure/error
// start tags, tracks nesting depth, flags done when the root closes and latches
// the first structural error.
// Ports:
//   clk, rst (sync, active high), clear (sync restart, rst has priority)
//   in_valid/in_ready/in_data[8]/in_last - input byte stream
//   suite_cnt, case_cnt, fail_cnt, err_cnt [CNT_W] - saturating tag counters
//   skip_cnt [CNT_W] - only when JUNIT_XML_READER_SKIP_CNT_EN is defined
//   depth [DEPTH_W], done, error, err_code[3] - registered status
// Build option: define JUNIT_XML_READER_SKIP_CNT_EN to count <skipped> tags.
//
// state   | meaning
// TEXT    | character data between tags, waiting for '<'
// LT      | just saw '<'
// NAME    | capturing an element name
// ATTR    | inside an open tag after the name
// QUOTE   | inside a quoted attribute value
// SLASH   | saw '/' in an open tag, expecting '>'
// CLOSE   | skipping a close tag up to '>'
// DECL    | skipping <? ... > or <! ... >
// DONE    | root element closed, input stalled
// ERR     | error latched, input stalled
module junit_xml_reader #(
  parameter int NAME_MAX = 16,
  parameter int CNT_W    = 16,
  parameter int DEPTH_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic [CNT_W-1:0]   suite_cnt,
  output logic [CNT_W-1:0]   case_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   err_cnt,
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
  output logic [CNT_W-1:0]   skip_cnt,
`endif
  output logic [DEPTH_W-1:0] depth,
  output logic               done,
  output logic               error,
  output logic [2:0]         err_code
);
  import junit_xml_reader_pkg::*;

  // One extra bit so the length can run past NAME_MAX and never alias a short name.
  localparam int LEN_W = $clog2(NAME_MAX + 1) + 1;
  localparam logic [LEN_W-1:0] NAME_MAX_L = LEN_W'(NAME_MAX);

  state_t                state, state_nx;
  logic [7:0]            quote, quote_nx;
  logic [8*NAME_MAX-1:0] name_buf, buf_nx;
  logic [LEN_W-1:0]      name_len, len_nx;
  logic [CNT_W-1:0]      suite_nx, case_nx, fail_nx, errc_nx;
  logic [DEPTH_W-1:0]    depth_nx;
  logic                  done_nx, error_nx;
  logic [2:0]            code_nx;
  logic [4:0]            match;
  logic                  accept;
  logic                  tag_open, tag_self, tag_close, bad_tag;
  logic                  ovf, unf, root_done, struct_err, trunc;
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
  logic [CNT_W-1:0]      skip_nx;
`else
  logic                  unused_skip_match;
  assign unused_skip_match = match[M_SKIPPED];
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  junit_xml_name_match #(
    .NAME_MAX(NAME_MAX),
    .LEN_W   (LEN_W)
  ) u_name_match (
    .name_buf(name_buf),
    .name_len(name_len),
    .match   (match)
  );

  assign in_ready = !done && !error;
  assign accept   = in_valid && in_ready && !clear;

  always_comb begin
    state_nx  = state;
    quote_nx  = quote;
    buf_nx    = name_buf;
    len_nx    = name_len;
    tag_open  = 1'b0;
    tag_self  = 1'b0;
    tag_close = 1'b0;
    bad_tag   = 1'b0;
    if (accept) begin
      case (state)
        ST_TEXT: begin
          if (in_data == CH_LT) begin
            state_nx = ST_LT;
            buf_nx   = '0;
            len_nx   = '0;
          end
        end
        ST_LT: begin
          if (in_data == CH_SLASH) begin
            state_nx = ST_CLOSE;
          end else if ((in_data == CH_QMARK) || (in_data == CH_BANG)) begin
            state_nx = ST_DECL;
          end else if (is_name_start(in_data)) begin
            buf_nx[7:0] = in_data;
            len_nx      = LEN_W'(1);
            state_nx    = ST_NAME;
          end else begin
            bad_tag = 1'b1;
          end
        end
        ST_NAME: begin
          if (is_name_char(in_data)) begin
            if (name_len < NAME_MAX_L) buf_nx[8*int'(name_len) +: 8] = in_data;
            if (name_len != '1) len_nx = name_len + LEN_W'(1);
          end else if (is_space(in_data)) begin
            state_nx = ST_ATTR;
          end else if (in_data == CH_SLASH) begin
            state_nx = ST_SLASH;
          end else if (in_data == CH_GT) begin
            tag_open = 1'b1;
            state_nx = ST_TEXT;
          end else begin
            bad_tag = 1'b1;
          end
        end
        ST_ATTR: begin
          if ((in_data == CH_DQUOTE) || (in_data == CH_SQUOTE)) begin
            quote_nx = in_data;
            state_nx = ST_QUOTE;
          end else if (in_data == CH_SLASH) begin
            state_nx = ST_SLASH;
          end else if (in_data == CH_GT) begin
            tag_open = 1'b1;
            state_nx = ST_TEXT;
          end
        end
        ST_QUOTE: begin
          if (in_data == quote) state_nx = ST_ATTR;
        end
        ST_SLASH: begin
          if (in_data == CH_GT) begin
            tag_self = 1'b1;
            state_nx = ST_TEXT;
          end else begin
            bad_tag = 1'b1;
          end
        end
        ST_CLOSE: begin
          if (in_data == CH_GT) begin
            tag_close = 1'b1;
            state_nx  = ST_TEXT;
          end
        end
        ST_DECL: begin
          if (in_data == CH_GT) state_nx = ST_TEXT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ovf        = tag_open && (depth == '1);
    unf        = tag_close && (depth == '0);
    root_done  = (tag_self && (depth == '0)) || (tag_close && (depth == DEPTH_W'(1)));
    struct_err = ovf || unf || bad_tag;
    trunc      = accept && in_last && !root_done && !struct_err;

    suite_nx = suite_cnt;
    case_nx  = case_cnt;
    fail_nx  = fail_cnt;
    errc_nx  = err_cnt;
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
    skip_nx  = skip_cnt;
`endif
    depth_nx = depth;
    done_nx  = done;
    error_nx = error;
    code_nx  = err_code;

    // A byte that trips a structural error leaves counters and depth untouched;
    // a truncating byte still completes whatever tag it closes.
    if (!struct_err) begin
      if (tag_open || tag_self) begin
        if (match[M_SUITE])   suite_nx = sat_inc(suite_cnt);
        if (match[M_CASE])    case_nx  = sat_inc(case_cnt);
        if (match[M_FAILURE]) fail_nx  = sat_inc(fail_cnt);
        if (match[M_ERROR])   errc_nx  = sat_inc(err_cnt);
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
        if (match[M_SKIPPED]) skip_nx  = sat_inc(skip_cnt);
`endif
      end
      if (tag_open)  depth_nx = depth + DEPTH_W'(1);
      if (tag_close) depth_nx = depth - DEPTH_W'(1);
    end

    if (ovf)          code_nx = ERR_OVERFLOW;
    else if (unf)     code_nx = ERR_UNDERFLOW;
    else if (bad_tag) code_nx = ERR_BAD_TAG;
    else if (trunc)   code_nx = ERR_TRUNC;

    if (struct_err || trunc) error_nx = 1'b1;
    else if (root_done)      done_nx  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= ST_TEXT;
      quote     <= '0;
      name_buf  <= '0;
      name_len  <= '0;
      suite_cnt <= '0;
      case_cnt  <= '0;
      fail_cnt  <= '0;
      err_cnt   <= '0;
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
      skip_cnt  <= '0;
`endif
      depth     <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      if (error_nx && !error)    state <= ST_ERR;
      else if (done_nx && !done) state <= ST_DONE;
      else                       state <= state_nx;
      quote     <= quote_nx;
      name_buf  <= buf_nx;
      name_len  <= len_nx;
      suite_cnt <= suite_nx;
      case_cnt  <= case_nx;
      fail_cnt  <= fail_nx;
      err_cnt   <= errc_nx;
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
      skip_cnt  <= skip_nx;
`endif
      depth     <= depth_nx;
      done      <= done_nx;
      error     <= error_nx;
      err_code  <= code_nx;
    end
  end

endmodule

// File: tb/tb_junit_xml_reader.sv
// Scoreboard bench for junit_xml_reader: each directed document pushes its
// expected final status; a monitor pops and compares when done or error rises.
module tb_junit_xml_reader;

  localparam int NAME_MAX = 16;
  localparam int CNT_W    = 2;
  localparam int DEPTH_W  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         in_data = 8'h00;
  logic               in_last = 1'b0;
  logic [CNT_W-1:0]   suite_cnt, case_cnt, fail_cnt, err_cnt;
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
  logic [CNT_W-1:0]   skip_cnt;
`endif
  logic [DEPTH_W-1:0] depth;
  logic               done, error;
  logic [2:0]         err_code;

  junit_xml_reader #(
    .NAME_MAX(NAME_MAX),
    .CNT_W   (CNT_W),
    .DEPTH_W (DEPTH_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .suite_cnt(suite_cnt),
    .case_cnt (case_cnt),
    .fail_cnt (fail_cnt),
    .err_cnt  (err_cnt),
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
    .skip_cnt (skip_cnt),
`endif
    .depth    (depth),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    int       suite, tcase, fail, err, skip, dep;
    int       dn, er, code;
    bit       chk_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   seen    = 1'b0;

  task automatic check(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Monitor: the DUT "presents" a result when done or error first rises.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else if ((done || error) && !seen) begin
      seen = 1'b1;
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check({e.name, ".done"},     int'(done),     e.dn);
        check({e.name, ".error"},    int'(error),    e.er);
        check({e.name, ".err_code"}, int'(err_code), e.code);
        check({e.name, ".in_ready"}, int'(in_ready), 0);
        if (e.chk_cnt) begin
          check({e.name, ".suite_cnt"}, int'(suite_cnt), e.suite);
          check({e.name, ".case_cnt"},  int'(case_cnt),  e.tcase);
          check({e.name, ".fail_cnt"},  int'(fail_cnt),  e.fail);
          check({e.name, ".err_cnt"},   int'(err_cnt),   e.err);
          check({e.name, ".depth"},     int'(depth),     e.dep);
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
          check({e.name, ".skip_cnt"},  int'(skip_cnt),  e.skip);
`endif
        end
      end
    end else if (!done && !error) begin
      seen = 1'b0;
    end
  end

  task automatic push(input string name, input int s, input int c, input int f, input int r,
                      input int k, input int d, input int dn, input int er, input int code,
                      input bit chk_cnt);
    exp_t e;
    e.name = name; e.suite = s; e.tcase = c; e.fail = f; e.err = r; e.skip = k;
    e.dep = d; e.dn = dn; e.er = er; e.code = code; e.chk_cnt = chk_cnt;
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; leaves in_valid asserted so bytes go back to back.
  task automatic send_byte(input logic [7:0] b, input bit last);
    int  budget;
    bit  took;
    budget   = 40;
    took     = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!took && budget > 0) begin
      took = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    if (!took) check("accept_timeout", 0, 1);
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], last && (i == s.len() - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (sb_q.size() != 0) begin
      check({name, ".result_timeout"}, 0, 1);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic do_clear(input string name);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check({name, ".clr_in_ready"}, int'(in_ready), 1);
    check({name, ".clr_status"},
          int'({done, error, err_code, depth}), 0);
    check({name, ".clr_counts"},
          int'({suite_cnt, case_cnt, fail_cnt, err_cnt}), 0);
  endtask

  string s;
  string dq;
  int    blocked;

  initial begin
    dq    = " ";
    dq[0] = 8'h22;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.in_ready", int'(in_ready), 1);
    check("reset.status", int'({done, error, err_code, depth}), 0);
    check("reset.counts", int'({suite_cnt, case_cnt, fail_cnt, err_cnt}), 0);

    // Nested report, root closed on the flagged last byte.
    push("report", 1, 2, 1, 0, 0, 0, 1, 0, 0, 1);
    s = {"<testsuites><testsuite name=", dq, "a", dq,
         "><testcase/><testcase><failure/></testcase></testsuite></testsuites>"};
    send_str(s, 1'b1);
    drain("report");
    do_clear("report");

    // Error tags both open/close and self-closing.
    push("errors", 1, 2, 1, 2, 0, 0, 1, 0, 0, 1);
    send_str("<testsuite><testcase><error/></testcase><testcase><error></error><failure/></testcase></testsuite>", 1'b1);
    drain("errors");
    do_clear("errors");

    // Declaration skipped, '>' inside single quotes ignored, self-closing root.
    push("decl_quote", 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    s = {"<?xml version=", dq, "1.0", dq, "?><testsuite a='x>y'/>"};
    send_str(s, 1'b1);
    drain("decl_quote");
    do_clear("decl_quote");

    // Root closes without last flag; trailing bytes must be refused.
    push("early_done", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    send_str("<a></a>", 1'b0);
    drain("early_done");
    blocked  = 0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (in_ready) blocked++;
    end
    in_valid = 1'b0;
    check("early_done.ready_cycles", blocked, 0);
    check("early_done.no_error", int'(error), 0);
    do_clear("early_done");

    // Close tag at depth 0.
    push("underflow", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    send_str("</a>", 1'b0);
    drain("underflow");
    do_clear("underflow");

    // Sixteen nested opens with a 4-bit depth counter.
    push("overflow", 0, 0, 0, 0, 0, 15, 0, 1, 2, 1);
    s = "";
    for (int i = 0; i < 16; i++) s = {s, "<x>"};
    send_str(s, 1'b0);
    drain("overflow");
    do_clear("overflow");

    // Whitespace right after '<'.
    push("bad_tag", 0, 0, 0, 0, 0, 0, 0, 1, 3, 1);
    send_str("< ", 1'b0);
    drain("bad_tag");
    do_clear("bad_tag");

    // Near-miss names: suffix, case, prefix, over-long capture.
`ifdef JUNIT_XML_READER_SKIP_CNT_EN
    push("names", 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
`else
    push("names", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
`endif
    send_str("<r><testcasefoo/><Testcase/><testcas/><testcaseAAAAAAAAAAAA/><skipped/></r>", 1'b1);
    drain("names");
    do_clear("names");

    // Open root flagged last: truncated stream.
    push("trunc", 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    send_str("<testsuite>", 1'b1);
    drain("trunc");
    do_clear("trunc");

    // Counter saturation at CNT_W=2.
    push("saturate", 0, 3, 0, 0, 0, 0, 1, 0, 0, 1);
    send_str("<r><testcase/><testcase/><testcase/><testcase/><testcase/></r>", 1'b1);
    drain("saturate");
    do_clear("saturate");

    // clear together with a valid byte mid-document: byte dropped, state restarted.
    send_str("<r>", 1'b0);
    check("mid_clear.depth_before", int'(depth), 1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("mid_clear.depth_after", int'(depth), 0);
    push("mid_clear", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    send_str("<r/>", 1'b1);
    drain("mid_clear");
    do_clear("mid_clear");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/junit_xml_reader.md
Name: junit_xml_reader

Overview:
Streaming byte-serial reader for JUnit-XML reports, the counterpart to the team's report writer, so testbench reports can be checked back in hardware or emulation. It consumes one ASCII byte per cycle over a valid/ready stream and tracks element nesting. It counts `<testsuite>`, `<testcase>`, `<failure>` and `<error>` start tags. When the root element closes it raises `done`. Malformed structure raises a sticky error with a code.

Parameters:
- NAME_MAX, 16: tag-name capture buffer depth in bytes; must be at least 9.
- CNT_W, 16: width of each element counter; counters saturate at all-ones.
- DEPTH_W, 4: nesting-depth counter width; the maximum depth is 2**DEPTH_W-1.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- clear, input, 1: synchronous restart to the post-reset state; `rst` has priority.
- in_valid, input, 1: input byte valid.
- in_ready, output, 1: reader accepts a byte.
- in_data, input, 8: ASCII byte.
- in_last, input, 1: marks the final byte of the stream.
- suite_cnt, output, CNT_W: count of `testsuite` start tags.
- case_cnt, output, CNT_W: count of `testcase` start tags.
- fail_cnt, output, CNT_W: count of `failure` start tags.
- err_cnt, output, CNT_W: count of `error` start tags.
- depth, output, DEPTH_W: current open-element depth.
- done, output, 1: root element closed; sticky.
- error, output, 1: malformed input; sticky.
- err_code, output, 3: 0=NONE, 1=UNDERFLOW, 2=OVERFLOW, 3=BAD_TAG, 4=TRUNC.

Behaviour:
- Reset / clear: all counters, `depth` and `err_code` are 0. `done` and `error` are 0. `in_ready` is 1. State is TEXT.
- `in_ready = !done && !error`. A byte is consumed only when `in_valid && in_ready`, one byte per cycle, no bubbles.
- All outputs are registered. A counter or depth update is visible the cycle after the `>` byte that completes the tag.
- FSM states: TEXT, LT, NAME, ATTR, QUOTE, SLASH, CLOSE, DECL, DONE, ERR.
  - TEXT: `<` goes to LT. Any other byte is ignored.
  - LT: `/` goes to CLOSE. `?` or `!` goes to DECL. A name-start character (A-Z, a-z, `_`) stores the first name byte and goes to NAME. Any other byte is a BAD_TAG error.
  - NAME: name characters (letters, digits, `_`, `-`, `.`, `:`) append to the buffer. Whitespace goes to ATTR. `/` goes to SLASH. `>` completes an open tag and goes to TEXT. Any other byte is BAD_TAG.
  - ATTR: `"` or `'` goes to QUOTE and records the quote character. `/` goes to SLASH. `>` completes an open tag. Other bytes are ignored.
  - QUOTE: only the matching quote character returns to ATTR. `>` and `<` are ignored inside quotes.
  - SLASH: `>` completes a self-closing tag. Any other byte is BAD_TAG.
  - CLOSE: all bytes are skipped until `>`, then a close is processed. Close names are not matched against open names.
  - DECL: all bytes are skipped until `>`. A `>` inside a comment ends the skip; this is a documented limitation.
- Name capture:
  - Bytes beyond NAME_MAX are dropped, and the name length keeps counting (saturating).
  - A match requires exact length and exact bytes. Comparison is case-sensitive.
  - The buffer and length are cleared on entering LT.
- Open tag completion:
  - The matching counter increments with saturation. Unrecognised names are counted nowhere.
  - If the tag is not self-closing, `depth` increments. An open tag at maximum depth sets OVERFLOW instead.
- Self-closing tag: counted, no depth change. A self-closing tag at depth 0 (a self-closing root) sets `done`.
- Close tag:
  - At depth 0 it sets UNDERFLOW.
  - Otherwise `depth` decrements. A transition from 1 to 0 sets `done` and enters DONE.
- `in_last`:
  - If the last accepted byte does not itself cause `done`, TRUNC is set.
  - If the same byte both completes the root and is marked last, the result is `done` with no error.
- Error priority when several conditions hit on one byte: OVERFLOW/UNDERFLOW, then BAD_TAG, then TRUNC.
- The first error latches `err_code` and enters ERR. Counters freeze at that point.
- `clear` asserted in the same cycle as an accepted byte: `clear` wins and the byte is dropped.
- `rst` mid-stream aborts parsing with no residue.

Optional Feature:
- Macro JUNIT_XML_READER_SKIP_CNT_EN.
- When defined: adds an output port `skip_cnt` [CNT_W] counting `skipped` start tags, with the same saturation and timing rules as the other counters.
- When undefined: the port is absent, and `skipped` is treated as an unrecognised name.

Decomposition:
- Package junit_xml_reader_pkg holds:
  - the state enum;
  - the err_code enum;
  - the byte constants for `<`, `>`, `/`, `?`, `!`, and the two quote characters;
  - the recognised tag names as packed byte-string constants with their lengths.
- Sub-module junit_xml_name_match: combinational. Takes the name buffer and length; returns a one-hot match vector {suite, case, failure, error, skipped}.

Test Plan:
- `<testsuites><testsuite name="a"><testcase/><testcase><failure/></testcase></testsuite></testsuites>`, last byte flagged → suite_cnt=1, case_cnt=2, fail_cnt=1, err_cnt=0, done=1, error=0, depth=0.
- `<?xml version="1.0"?><testsuite a='x>y'/>` → the declaration and the quoted `>` are ignored; suite_cnt=1, done=1 via self-closing root, depth=0.
- `<a></a></b>` with no flags → done asserts after `</a>`, in_ready=0, so `</b>` is never accepted; error=0. Separately, `</a>` fed at reset → err_code=1 (UNDERFLOW).
- 16 nested `<x>` tags with DEPTH_W=4 → the 16th tag gives err_code=2, depth=15, and in_ready drops.
- `< testcase>` → err_code=3 (BAD_TAG). Separately, `<testcasefoo>` and `<Testcase>` → case_cnt stays 0.
- `<testsuite>` with the final `>` flagged last → err_code=4 (TRUNC). Then pulse `clear` → all outputs return to 0 and in_ready=1. With CNT_W=2, five `<testcase/>` tags inside a root → case_cnt=3 (saturated).
